// File: rtl/axi_pkg.sv
// Shared AXI constants and AR-channel state encodings, used by both the
// instruction-side and data-side bridges.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

endpackage

// File: rtl/inst_axi_bridge.sv
// Fetch-stage SRAM-like instruction port to AXI4 read-only master, in-order, single ID.
// Optional INST_BRIDGE_PERF_EN adds perf_req_cnt / perf_wait_cnt counter ports.
module inst_axi_bridge
    import axi_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef INST_BRIDGE_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    ar_state_e        ar_state_q;
    logic             arvalid_q;
    logic [31:0]      araddr_q;
    logic [2:0]       arsize_q;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             addr_ok;
    logic             r_hs;

    // The capacity check uses the registered count, so a retiring cycle still blocks.
    assign addr_ok = ~reset & (ar_state_q == AR_IDLE) & inst_sram_req & ~inst_sram_wr
                   & (outst_q < CNT_W'(MAX_OUTST));
    assign rready  = (outst_q != '0);
    assign r_hs    = rvalid & rready;

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = r_hs;
    assign inst_sram_rdata   = rdata;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;

    always_comb begin
        // NOTE: default first so every path assigns outst_d and no latch is inferred.
        outst_d = outst_q;
        case ({addr_ok, r_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only; sequential state uses <= exclusively.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arsize_q   <= '0;
            outst_q    <= '0;
        end else begin
            outst_q <= outst_d;
            case (ar_state_q)
                AR_IDLE: begin
                    if (addr_ok) begin
                        araddr_q   <= inst_sram_addr;
                        arsize_q   <= {1'b0, inst_sram_size};
                        arvalid_q  <= 1'b1;
                        ar_state_q <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        arvalid_q  <= 1'b0;
                        ar_state_q <= AR_IDLE;
                    end
                end
                default: begin
                    arvalid_q  <= 1'b0;
                    ar_state_q <= AR_IDLE;
                end
            endcase
        end
    end

`ifdef INST_BRIDGE_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_req_q  <= '0;
            perf_wait_q <= '0;
        end else begin
            if (addr_ok)
                perf_req_q <= perf_req_q + 32'd1;
            if (rready & ~r_hs)
                perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_req_cnt  = perf_req_q;
    assign perf_wait_cnt = perf_wait_q;
`endif

    // Write-side and response-status inputs are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast, 1'b0};

`ifndef SYNTHESIS
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(rvalid && (outst_q == '0)));
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge (default MAX_OUTST=2); perf counters checked
// only when INST_BRIDGE_PERF_EN is defined.
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
`ifdef INST_BRIDGE_PERF_EN
    logic [31:0] perf_req_cnt, perf_wait_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    inst_axi_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
`ifdef INST_BRIDGE_PERF_EN
        ,
        .perf_req_cnt      (perf_req_cnt),
        .perf_wait_cnt     (perf_wait_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    // Issue one request and complete its AR handshake; leaves the bridge in AR_IDLE.
    task automatic issue(input logic [31:0] a);
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        inst_sram_size = 2'd2;
        tick();
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // Reference model state for the random phase.
    bit          m_send;
    int          m_outst;
    logic [31:0] m_addr;
    bit          e_ok, e_hs;

    initial begin
        reset = 1'b1;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
        arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        settle();

        // Reset state and constant AR fields
        check_eq("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("rst_arsize", {29'd0, arsize}, 32'd0);
        check_eq("rst_rready", {31'd0, rready}, 32'd0);
        check_eq("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        check_eq("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        check_eq("const_ar", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
                 {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 9'd0});

        // 1. Single fetch
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        settle();
        check_eq("t1_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        check_eq("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check_eq("t1_araddr", araddr, 32'h1C00_0000);
        check_eq("t1_arsize", {29'd0, arsize}, 32'd2);
        check_eq("t1_rready", {31'd0, rready}, 32'd1);
        tick();
        arready = 1'b0;
        settle();
        check_eq("t1_arvalid_lo", {31'd0, arvalid}, 32'd0);
        tick(); tick();
        rvalid = 1'b1; rdata = 32'h0280_0000;
        settle();
        check_eq("t1_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check_eq("t1_rdata", inst_sram_rdata, 32'h0280_0000);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t1_rready_lo", {31'd0, rready}, 32'd0);

        // 2. arready held low for 5 cycles
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010;
        settle();
        check_eq("t2_addr_ok_a", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_addr = 32'h1C00_0020;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq($sformatf("t2_arvalid%0d", i), {31'd0, arvalid}, 32'd1);
            check_eq($sformatf("t2_araddr%0d", i), araddr, 32'h1C00_0010);
            check_eq($sformatf("t2_addr_ok_blk%0d", i), {31'd0, inst_sram_addr_ok}, 32'd0);
            tick();
        end
        arready = 1'b1;
        settle();
        check_eq("t2_addr_ok_send", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();
        arready = 1'b0;
        settle();
        check_eq("t2_addr_ok_b", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        check_eq("t2_araddr_b", araddr, 32'h1C00_0020);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hAAAA_0001;
        settle();
        check_eq("t2_data_ok_a", {31'd0, inst_sram_data_ok}, 32'd1);
        tick();
        rdata = 32'hAAAA_0002;
        settle();
        check_eq("t2_data_ok_b", {31'd0, inst_sram_data_ok}, 32'd1);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t2_drained", {31'd0, rready}, 32'd0);

        // 3. A, B, C with the outstanding limit reached
        issue(32'h0000_A000);
        issue(32'h0000_B000);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_C000;
        settle();
        check_eq("t3_full0", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();
        settle();
        check_eq("t3_full1", {31'd0, inst_sram_addr_ok}, 32'd0);
        rvalid = 1'b1; rdata = 32'hDA7A_000A;
        settle();
        check_eq("t3_data_a", inst_sram_rdata, 32'hDA7A_000A);
        check_eq("t3_ok_a", {31'd0, inst_sram_data_ok}, 32'd1);
        check_eq("t3_retire_blk", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t3_addr_ok_c", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        check_eq("t3_araddr_c", araddr, 32'h0000_C000);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hDA7A_000B;
        settle();
        check_eq("t3_ok_b", {31'd0, inst_sram_data_ok}, 32'd1);
        tick();
        rdata = 32'hDA7A_000C;
        settle();
        check_eq("t3_ok_c", {31'd0, inst_sram_data_ok}, 32'd1);
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t3_drained", {31'd0, rready}, 32'd0);

        // 4. Same-cycle retire and accept at outst=1
        issue(32'h0000_1000);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_2000;
        rvalid = 1'b1; rdata = 32'h1111_1111;
        settle();
        check_eq("t4_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        check_eq("t4_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0; rvalid = 1'b0; arready = 1'b1;
        settle();
        check_eq("t4_rready_one", {31'd0, rready}, 32'd1);
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        settle();
        check_eq("t4_zero", {31'd0, rready}, 32'd0);

        // 4b. 100 random cycles against a small reference model
        m_send = 1'b0; m_outst = 0; m_addr = 32'h0000_1000;
        for (int i = 0; i < 100; i++) begin
            inst_sram_req  = 1'($urandom_range(0, 1));
            inst_sram_addr = {$urandom} & 32'hFFFF_FFFC;
            inst_sram_size = 2'd2;
            arready        = 1'($urandom_range(0, 1));
            rvalid         = (m_outst != 0) && ($urandom_range(0, 1) == 1);
            rdata          = $urandom;
            settle();
            e_ok = !m_send && inst_sram_req && (m_outst < 2);
            e_hs = rvalid && (m_outst != 0);
            check_eq("rnd_addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, e_ok});
            check_eq("rnd_rready", {31'd0, rready}, {31'd0, m_outst != 0});
            check_eq("rnd_arvalid", {31'd0, arvalid}, {31'd0, m_send});
            if (m_send)
                check_eq("rnd_araddr", araddr, m_addr);
            if (e_ok) begin
                m_send = 1'b1;
                m_addr = inst_sram_addr;
            end else if (m_send && arready) begin
                m_send = 1'b0;
            end
            m_outst = m_outst + int'(e_ok) - int'(e_hs);
            tick();
        end
        check_eq("rnd_outst_range", {31'd0, m_outst > 2}, 32'd0);

        // 5. Reset while outst=2 and arvalid=1
        inst_sram_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(32'h0000_5000);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_6000;
        tick();
        inst_sram_req = 1'b0;
        settle();
        check_eq("t5_pre_arvalid", {31'd0, arvalid}, 32'd1);
        check_eq("t5_pre_rready", {31'd0, rready}, 32'd1);
        reset = 1'b1;
        tick();
        settle();
        check_eq("t5_arvalid", {31'd0, arvalid}, 32'd0);
        check_eq("t5_rready", {31'd0, rready}, 32'd0);
        check_eq("t5_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        check_eq("t5_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        check_eq("t5_araddr", araddr, 32'd0);
        reset = 1'b0;
        tick();

`ifdef INST_BRIDGE_PERF_EN
        // 6. Three reads, each waiting four cycles
        for (int i = 0; i < 3; i++) begin
            inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_7000 + 32'(i * 4);
            tick();
            inst_sram_req = 1'b0; arready = 1'b1;
            tick();
            arready = 1'b0;
            tick(); tick(); tick();
            rvalid = 1'b1;
            tick();
            rvalid = 1'b0;
        end
        settle();
        check_eq("t6_req_cnt", perf_req_cnt, 32'd3);
        check_eq("t6_wait_cnt", perf_wait_cnt, 32'd12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
